audio_adc_rx: RTL and testbench

Receives the serial ADC stream from the audio codec (AUD_ADCLRCK, AUD_BCLK, AUD_ADCDAT) and deserializes it into parallel signed left/right samples in the iCLK domain. It is the capture path that complements the DAC-side sample generators. Codec serial signals are sampled by iCLK oversampling, not by using BCLK as a clock. Output is one stereo sample pair per LRCK frame, with a one-cycle valid strobe and a saturating framing-error count.

---
 rtl/audio_adc_rx.sv | 207 ++++++++++++++++++++
 tb/tb_audio_adc_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// audio_adc_rx
//   Captures the codec's left-justified serial ADC stream and produces parallel
//   signed left/right samples in the iCLK domain. The codec signals are
//   oversampled by iCLK; BCLK is never used as a clock. One stereo pair is
//   presented per LRCK frame with a one-cycle strobe, and framing problems are
//   counted in a saturating 8-bit counter.
//
//   Optional feature: define AUDIO_ADC_RX_PEAK_HOLD_EN to build a peak-absolute
//   value tracker on oPEAK (cleared by iPEAK_CLR). Without it oPEAK reads 0.
//
// Ports
//   iCLK          system clock, at least 8x BCLK
//   iRST_N        asynchronous active-low reset
//   iAUD_BCLK     codec bit clock (asynchronous)
//   iAUD_ADCLRCK  codec left/right clock (asynchronous)
//   iAUD_ADCDAT   codec serial data (asynchronous)
//   oAUD_inL      last complete left sample (signed)
//   oAUD_inR      last complete right sample (signed)
//   oVALID        one-cycle pulse when oAUD_inL/oAUD_inR update
//   oERR_CNT      saturating framing-error count
//   iPEAK_CLR     synchronous clear of oPEAK
//   oPEAK         peak absolute sample value
module audio_adc_rx #(
  parameter int   DATA_W   = 16,
  parameter logic LEFT_LVL = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iAUD_BCLK,
  input  logic              iAUD_ADCLRCK,
  input  logic              iAUD_ADCDAT,
  output logic [DATA_W-1:0] oAUD_inL,
  output logic [DATA_W-1:0] oAUD_inR,
  output logic              oVALID,
  output logic [7:0]        oERR_CNT,
  input  logic              iPEAK_CLR,
  output logic [DATA_W-1:0] oPEAK
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t state, state_nxt;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic lr_s1, lr_s2, dat_s1, dat_s2;
  logic lr_prev;
  logic tick, lr_change;

  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              is_left, is_left_nxt;
  logic [DATA_W-1:0] stage_left, stage_nxt;
  logic              left_ok, left_ok_nxt;
  logic [DATA_W-1:0] out_l, out_l_nxt, out_r, out_r_nxt;
  logic              valid_nxt;
  logic [7:0]        err_cnt, err_nxt;
  logic              word_done, err_inc;

  // Bring the asynchronous codec lines into iCLK; the third BCLK flop gives
  // the previous value for rising-edge detection.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      dat_s1  <= 1'b0;
      dat_s2  <= 1'b0;
    end else begin
      bclk_s1 <= iAUD_BCLK;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lr_s1   <= iAUD_ADCLRCK;
      lr_s2   <= lr_s1;
      dat_s1  <= iAUD_ADCDAT;
      dat_s2  <= dat_s1;
    end
  end

  assign tick      = bclk_s2 & ~bclk_s3;
  assign lr_change = (lr_s2 != lr_prev);

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and datapath. Any LRCK change begins a new word with this
  // tick's bit as MSB; a change in the middle of a word is a framing error.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    is_left_nxt = is_left;
    word_done   = 1'b0;
    err_inc     = 1'b0;
    if (tick) begin
      if (lr_change) begin
        if (state == SHIFT) err_inc = 1'b1;
        shreg_nxt   = {{(DATA_W-1){1'b0}}, dat_s2};
        cnt_nxt     = CNT_W'(1);
        is_left_nxt = (lr_s2 == LEFT_LVL);
        state_nxt   = SHIFT;
      end else if (state == SHIFT) begin
        shreg_nxt = {shreg[DATA_W-2:0], dat_s2};
        cnt_nxt   = bit_cnt + 1'b1;
        if (cnt_nxt == CNT_W'(DATA_W)) begin
          word_done = 1'b1;
          state_nxt = HOLD;
        end
      end
    end

    // A right word only produces output if a left word is staged ahead of it.
    stage_nxt   = stage_left;
    left_ok_nxt = left_ok;
    out_l_nxt   = out_l;
    out_r_nxt   = out_r;
    valid_nxt   = 1'b0;
    if (word_done) begin
      if (is_left) begin
        stage_nxt   = shreg_nxt;
        left_ok_nxt = 1'b1;
      end else if (left_ok) begin
        out_l_nxt   = stage_left;
        out_r_nxt   = shreg_nxt;
        valid_nxt   = 1'b1;
        left_ok_nxt = 1'b0;
      end else begin
        err_inc = 1'b1;
      end
    end

    err_nxt = err_cnt;
    if (err_inc && (err_cnt != 8'hFF)) err_nxt = err_cnt + 8'd1;
  end

  // Datapath registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lr_prev    <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      is_left    <= 1'b0;
      stage_left <= '0;
      left_ok    <= 1'b0;
      out_l      <= '0;
      out_r      <= '0;
      oVALID     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (tick) lr_prev <= lr_s2;
      bit_cnt    <= cnt_nxt;
      shreg      <= shreg_nxt;
      is_left    <= is_left_nxt;
      stage_left <= stage_nxt;
      left_ok    <= left_ok_nxt;
      out_l      <= out_l_nxt;
      out_r      <= out_r_nxt;
      oVALID     <= valid_nxt;
      err_cnt    <= err_nxt;
    end
  end

  assign oAUD_inL = out_l;
  assign oAUD_inR = out_r;
  assign oERR_CNT = err_cnt;

`ifdef AUDIO_ADC_RX_PEAK_HOLD_EN
  // Absolute value; the most negative code has no positive twin, so it
  // saturates to the largest positive code.
  function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x[DATA_W-1])                return -x;
    else                                 return x;
  endfunction

  logic [DATA_W-1:0] abs_l, abs_r, pair_max, peak;

  assign abs_l    = sat_abs(stage_left);
  assign abs_r    = sat_abs(shreg_nxt);
  assign pair_max = (abs_l > abs_r) ? abs_l : abs_r;

  // Peak updates in step with the output registers; a clear that coincides
  // with a new pair restarts the peak from that pair.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      peak <= '0;
    end else if (valid_nxt) begin
      if (iPEAK_CLR || (pair_max > peak)) peak <= pair_max;
    end else if (iPEAK_CLR) begin
      peak <= '0;
    end
  end

  assign oPEAK = peak;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = iPEAK_CLR;
  assign oPEAK = '0;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx
//   Directed bench for audio_adc_rx: drives BCLK at iCLK/16 with left-justified
//   frames and compares outputs against hand-computed values.
module tb_audio_adc_rx;

`ifdef AUDIO_ADC_RX_PEAK_HOLD_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aud_bclk = 1'b0;
  logic        aud_lrck = 1'b0;
  logic        aud_dat = 1'b0;
  logic        peak_clr = 1'b0;
  logic [15:0] in_l, in_r, peak;
  logic        valid;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int v0;

  audio_adc_rx dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .iAUD_BCLK(aud_bclk),
    .iAUD_ADCLRCK(aud_lrck),
    .iAUD_ADCDAT(aud_dat),
    .oAUD_inL(in_l),
    .oAUD_inR(in_r),
    .oVALID(valid),
    .oERR_CNT(err_cnt),
    .iPEAK_CLR(peak_clr),
    .oPEAK(peak)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Count every cycle the strobe is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) valid_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One BCLK period of 16 iCLK; LRCK/DAT change while BCLK is low.
  task automatic send_bit(input logic lvl, input logic b);
    @(negedge clk);
    aud_lrck = lvl;
    aud_dat  = b;
    repeat (8) @(negedge clk);
    aud_bclk = 1'b1;
    repeat (8) @(negedge clk);
    aud_bclk = 1'b0;
  endtask

  // Send nbits of word starting at MSB-relative index first.
  task automatic send_bits(input logic lvl, input logic [15:0] word,
                           input int first, input int nbits);
    logic [15:0] w;
    w = word;
    for (int i = 0; i < nbits; i++) send_bit(lvl, w[15 - first - i]);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_bits(1'b1, l, 0, 16);
    send_bits(1'b0, r, 0, 16);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [15:0] nw;
    $display("[TB] starting audio_adc_rx bench");

    // Reset state
    repeat (5) @(negedge clk);
    check_output("rst_inL", 32'(in_l), 32'h0);
    check_output("rst_inR", 32'(in_r), 32'h0);
    check_output("rst_valid", 32'(valid), 32'h0);
    check_output("rst_err", 32'(err_cnt), 32'h0);
    check_output("rst_peak", 32'(peak), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Idle ticks at the right-channel level, then one full frame
    send_bits(1'b0, 16'h0000, 0, 2);
    send_frame(16'h1234, 16'hABCD);
    check_output("frame_valid_cnt", 32'(valid_cnt), 32'd1);
    check_output("frame_inL", 32'(in_l), 32'h1234);
    check_output("frame_inR", 32'(in_r), 32'hABCD);
    check_output("frame_err", 32'(err_cnt), 32'h0);

    // Back-to-back frames L=n, R=~n
    for (int n = 0; n < 48; n++) begin
      nw = ~16'(n);
      send_bits(1'b1, 16'(n), 0, 16);
      send_bits(1'b0, nw, 0, 16);
      check_output("b2b_inL", 32'(in_l), 32'(n));
      check_output("b2b_inR", 32'(in_r), 32'(nw));
      check_output("b2b_valid_cnt", 32'(valid_cnt), 32'(n + 2));
    end
    repeat (4) @(negedge clk);
    check_output("b2b_total_valid", 32'(valid_cnt), 32'd49);
    check_output("b2b_err", 32'(err_cnt), 32'h0);

    // Short left word, then an orphan right word
    send_bits(1'b1, 16'hFFFF, 0, 10);
    send_bits(1'b0, 16'h0F0F, 0, 1);
    repeat (4) @(negedge clk);
    check_output("short_err1", 32'(err_cnt), 32'd1);
    send_bits(1'b0, 16'h0F0F, 1, 15);
    repeat (4) @(negedge clk);
    check_output("short_err2", 32'(err_cnt), 32'd2);
    check_output("short_valid_cnt", 32'(valid_cnt), 32'd49);
    check_output("short_inL", 32'(in_l), 32'h002F);
    check_output("short_inR", 32'(in_r), 32'hFFD0);

    // 300 consecutive short words saturate the error counter
    for (int k = 0; k < 300; k++) send_bits(((k % 2) == 0), 16'hA5A5, 0, 3);
    repeat (4) @(negedge clk);
    check_output("sat_err", 32'(err_cnt), 32'd255);
    check_output("sat_valid_cnt", 32'(valid_cnt), 32'd49);

    // Reset during bit 7 of a left word
    v0 = valid_cnt;
    send_bits(1'b1, 16'h1357, 0, 6);
    @(negedge clk);
    aud_lrck = 1'b1;
    aud_dat  = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_inL", 32'(in_l), 32'h0);
    check_output("midrst_inR", 32'(in_r), 32'h0);
    check_output("midrst_valid", 32'(valid), 32'h0);
    check_output("midrst_err", 32'(err_cnt), 32'h0);
    check_output("midrst_peak", 32'(peak), 32'h0);
    aud_bclk = 1'b0;
    aud_lrck = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_output("midrst_no_valid", 32'(valid_cnt), 32'(v0));
    send_frame(16'h5555, 16'hAAAA);
    check_output("postrst_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));
    check_output("postrst_inL", 32'(in_l), 32'h5555);
    check_output("postrst_inR", 32'(in_r), 32'hAAAA);
    check_output("postrst_err", 32'(err_cnt), 32'h0);

    // Peak hold
    send_frame(16'h8000, 16'h0100);
    check_output("peak_most_neg", 32'(peak), PEAK_ON ? 32'h7FFF : 32'h0);
    send_frame(16'h0200, 16'hFFFF);
    check_output("peak_held", 32'(peak), PEAK_ON ? 32'h7FFF : 32'h0);
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    @(negedge clk);
    check_output("peak_cleared", 32'(peak), 32'h0);
    send_frame(16'h0200, 16'hFFFF);
    check_output("peak_after_clr", 32'(peak), PEAK_ON ? 32'h0200 : 32'h0);
    check_output("peak_frame_inL", 32'(in_l), 32'h0200);
    check_output("peak_frame_inR", 32'(in_r), 32'hFFFF);
    check_output("final_err", 32'(err_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
